small_lpf_2nd: RTL and testbench
================================

SMALL_LPF_2ND -- requirements
Module: small_lpf_2nd

Interface
REQ-001 The block SHALL have parameter K0_SHIFT, default 6: stage-0 coefficient k0 = 2^-K0_SHIFT, legal range 1..16.
REQ-002 The block SHALL have parameter K1_SHIFT, default 6: stage-1 coefficient k1 = 2^-K1_SHIFT, legal range 1..16.
REQ-003 The block SHALL have parameter WIDTH, default 16: signed data path width, legal range 2..32.
REQ-004 The block SHALL have parameter CLAMP, default 1: 1 = saturating accumulators, 0 = wrapping accumulators.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port en, input, 1 bit: filter enable; state updates only when en=1.
REQ-008 The block SHALL have port dataIn, input, WIDTH bits signed (two's complement): filter input sample.
REQ-009 The block SHALL have port dataOut, output, WIDTH bits signed: filter output sample.

Function
REQ-010 The filter SHALL be two cascaded first-order leaky integrators, giving a 2nd-order low-pass with unity DC gain.
REQ-011 The block SHALL hold acc0 as a signed register of WIDTH+K0_SHIFT bits and acc1 as a signed register of WIDTH+K1_SHIFT bits.
REQ-012 The block SHALL form s0 = acc0 >>> K0_SHIFT (arithmetic shift, floor) and s1 = acc1 >>> K1_SHIFT; both are WIDTH bits.
REQ-013 On a rising edge with en=1, acc0 SHALL become acc0 + dataIn - s0, with the sum computed at WIDTH+K0_SHIFT+2 bits.
REQ-014 On the same edge, acc1 SHALL become acc1 + s0 - s1, with the sum computed at WIDTH+K1_SHIFT+2 bits; s0 is the value before the edge, so both accumulators update simultaneously from pre-edge state.
REQ-015 dataOut SHALL equal s1, combinationally from the acc1 register, with no extra output register.
REQ-016 Latency: a dataIn change SHALL first affect acc0 at edge 1 and dataOut after edge 2.
REQ-017 When CLAMP=1, each accumulator sum SHALL saturate to its signed register range: max 2^(W+K-1)-1, min -2^(W+K-1).
REQ-018 When CLAMP=0, each accumulator sum SHALL be truncated (wrapped) to its register width.
REQ-019 When en=0, acc0, acc1 and dataOut SHALL hold their values; dataIn SHALL be ignored.
REQ-020 For a constant input X held long enough, dataOut SHALL settle to exactly X, for any legal X including -2^(WIDTH-1) and 2^(WIDTH-1)-1.
REQ-021 No internal value SHALL be rounded other than by the arithmetic floor shifts defined above.

Reset
REQ-022 While rst=1, acc0 and acc1 SHALL be 0 and dataOut SHALL be 0, asynchronously and independent of clk and en.
REQ-023 Assertion of rst mid-operation SHALL clear all state immediately; on the first rising edge after deassertion with en=1, the normal update SHALL resume from zero state.

Verification
REQ-024 The bench SHALL cover reset: rst=1 with arbitrary dataIn and en=1 -> dataOut=0; after release with dataIn=0, dataOut stays 0.
REQ-025 The bench SHALL cover the step response at defaults: step to dataIn=16384 from reset -> after edge 1 acc0=16384 and dataOut=0; after edge 2 acc0=32512, acc1=256, dataOut=4; after 3000 edges dataOut=16384 exactly.
REQ-026 The bench SHALL cover the negative full-scale step at defaults: dataIn=-32768 held 3000 edges -> dataOut=-32768 exactly, with no wrap and no overshoot beyond range.
REQ-027 The bench SHALL cover enable hold: mid-step, set en=0 for 10 cycles -> dataOut constant; set en=1 -> response continues as if the pause never occurred.
REQ-028 The bench SHALL cover the chirp: dataIn = round(sin(i^2*pi/1e6)*16383) for i=1..65535 -> dataOut amplitude ~16383 at low frequency and strongly attenuated (below 10% of input) near the end of the sweep.
REQ-029 The bench SHALL cover random input: 65535 uniform random WIDTH-bit samples with CLAMP=1 -> dataOut stays within [-32768,32767], never wraps sign, and approximates the input mean.

Source files
------------

// File: rtl/small_lpf_2nd.sv
// small_lpf_2nd: 2nd-order low-pass, two cascaded leaky integrators, unity DC gain (clk, rst async, en, dataIn -> dataOut)
module small_lpf_2nd #(
  parameter int K0_SHIFT = 6,
  parameter int K1_SHIFT = 6,
  parameter int WIDTH = 16,
  parameter int CLAMP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] dataIn,
  output logic signed [WIDTH-1:0] dataOut
);
  localparam int A0 = WIDTH + K0_SHIFT;
  localparam int A1 = WIDTH + K1_SHIFT;
  logic signed [A0-1:0] acc0, nxt0;
  logic signed [A1-1:0] acc1, nxt1;
  logic signed [WIDTH-1:0] s0, s1;
  logic [A0+1:0] sum0;
  logic [A1+1:0] sum1;
  logic ovf0, ovf1;
  assign s0 = acc0[A0-1:K0_SHIFT];
  assign s1 = acc1[A1-1:K1_SHIFT];
  assign sum0 = {{2{acc0[A0-1]}}, acc0} + {{(K0_SHIFT+2){dataIn[WIDTH-1]}}, dataIn} - {{(K0_SHIFT+2){s0[WIDTH-1]}}, s0};
  assign sum1 = {{2{acc1[A1-1]}}, acc1} + {{(K1_SHIFT+2){s0[WIDTH-1]}}, s0} - {{(K1_SHIFT+2){s1[WIDTH-1]}}, s1};
  assign ovf0 = |sum0[A0+1:A0-1] && !(&sum0[A0+1:A0-1]);
  assign ovf1 = |sum1[A1+1:A1-1] && !(&sum1[A1+1:A1-1]);
  always_comb begin
    nxt0 = (CLAMP != 0 && ovf0) ? (sum0[A0+1] ? {1'b1, {(A0-1){1'b0}}} : {1'b0, {(A0-1){1'b1}}}) : sum0[A0-1:0];
    nxt1 = (CLAMP != 0 && ovf1) ? (sum1[A1+1] ? {1'b1, {(A1-1){1'b0}}} : {1'b0, {(A1-1){1'b1}}}) : sum1[A1-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc0 <= '0;
      acc1 <= '0;
    end else if (en) begin
      acc0 <= nxt0;
      acc1 <= nxt1;
    end
  assign dataOut = s1;
endmodule

// File: tb/tb_small_lpf_2nd.sv
// tb_small_lpf_2nd: scoreboard bench for small_lpf_2nd at default parameters
module tb_small_lpf_2nd;
  localparam int W = 16;
  localparam int K0 = 6;
  localparam int K1 = 6;
  localparam int CL = 1;
  logic clk = 0;
  logic rst = 1;
  logic en = 1;
  logic signed [W-1:0] dataIn = 0;
  logic signed [W-1:0] dataOut;
  int errs = 0;
  int checks = 0;
  longint m0 = 0;
  longint m1 = 0;
  longint exp_q[$];
  small_lpf_2nd #(.K0_SHIFT(K0), .K1_SHIFT(K1), .WIDTH(W), .CLAMP(CL)) dut (
    .clk(clk), .rst(rst), .en(en), .dataIn(dataIn), .dataOut(dataOut)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  function automatic longint fix(input longint v, input int w);
    longint mx = (64'sd1 <<< (w - 1)) - 1;
    if (CL != 0) return v > mx ? mx : (v < -mx - 1 ? -mx - 1 : v);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction
  task automatic drive(input longint x, input logic e);
    longint s0, s1;
    dataIn = x[W-1:0];
    en = e;
    @(posedge clk);
    if (e) begin
      s0 = m0 >>> K0;
      s1 = m1 >>> K1;
      m0 = fix(m0 + x - s0, W + K0);
      m1 = fix(m1 + s0 - s1, W + K1);
    end
    exp_q.push_back(m1 >>> K1);
    #1;
    if (exp_q.size() == 0) chk("sb_empty", 1, 0);
    else chk("sb", dataOut, exp_q.pop_front());
  endtask
  function automatic longint rnd(input real v);
    return v >= 0.0 ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
  endfunction
  initial begin
    longint mx, y, sin_v, sum_in, sum_out, d;
    real r;
    logic signed [W-1:0] rv;
    dataIn = 16'sd1234;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", dataOut, 0);
    chk("rst_acc0", dut.acc0, 0);
    chk("rst_acc1", dut.acc1, 0);
    rst = 0;
    repeat (5) drive(0, 1);
    chk("idle_out", dataOut, 0);
    drive(16384, 1);
    chk("e1_acc0", dut.acc0, 16384);
    chk("e1_out", dataOut, 0);
    drive(16384, 1);
    chk("e2_acc0", dut.acc0, 32512);
    chk("e2_acc1", dut.acc1, 256);
    chk("e2_out", dataOut, 4);
    repeat (150) drive(16384, 1);
    repeat (10) drive(longint'($urandom_range(0, 65535)) - 32768, 0);
    repeat (2848) drive(16384, 1);
    chk("step_pos", dataOut, 16384);
    #3 rst = 1;
    #1;
    chk("arst_out", dataOut, 0);
    chk("arst_acc0", dut.acc0, 0);
    m0 = 0;
    m1 = 0;
    en = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold", dataOut, 0);
    rst = 0;
    repeat (3000) drive(-32768, 1);
    chk("step_neg", dataOut, -32768);
    repeat (3000) drive(32767, 1);
    chk("step_max", dataOut, 32767);
    mx = 0;
    for (int i = 1; i <= 2000; i++) begin
      r = i;
      sin_v = rnd($sin(r * r * 3.14159265358979 / 1.0e6) * 16383.0);
      drive(sin_v, 1);
      y = dataOut < 0 ? -dataOut : dataOut;
      if (y > mx) mx = y;
    end
    chk("chirp_low", mx >= 13000, 1);
    mx = 0;
    for (int i = 56000; i <= 65535; i++) begin
      r = i;
      sin_v = rnd($sin(r * r * 3.14159265358979 / 1.0e6) * 16383.0);
      drive(sin_v, 1);
      y = dataOut < 0 ? -dataOut : dataOut;
      if (i > 57000 && y > mx) mx = y;
    end
    chk("chirp_high", mx < 1638, 1);
    sum_in = 0;
    sum_out = 0;
    for (int i = 0; i < 20000; i++) begin
      rv = W'($urandom);
      drive(rv, 1);
      if (i >= 5000) begin
        sum_in += rv;
        sum_out += dataOut;
      end
    end
    d = (sum_in - sum_out) / 15000;
    chk("rand_mean", d < 300 && d > -300, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
